pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder.sv | 148 ++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor built from 4-bit carry-lookahead groups.
// Each pipeline stage resolves WIDTH/(4*STAGES) groups, and the group carry
// ripples from one group to the next. Each stage register holds the partial
// sum, the inter-group carry, the operands that are still needed, and a valid
// bit. All stages advance together whenever the output is free or being taken.
module pipelined_cla_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int GPS  = WIDTH / (4 * STAGES);
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] a_d   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  logic [WIDTH-1:0] b_d   [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];
  logic             c_q   [STAGES];
  logic             c_d   [STAGES];
  logic             cm_q  [STAGES];
  logic             cm_d  [STAGES];
  logic             v_q   [STAGES];
  logic             v_d   [STAGES];

  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_b   [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_c   [STAGES];
  logic             src_v   [STAGES];

  logic adv;

  // 4-bit lookahead group: returns {carry out, carry into bit 3, sum[3:0]}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic c0);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & c0);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c0);
    return {c4, c3, p ^ {c3, c2, c1, c0}};
  endfunction

  // Global advance: the whole pipe moves whenever the output slot is free or being taken.
  always_comb begin
    adv      = out_ready | ~v_q[LAST];
    in_ready = adv;
  end

  // Stage inputs: stage 0 sees the ports (with the subtract operands applied), later stages see the previous register.
  always_comb begin
    src_a[0]   = a;
    src_b[0]   = sub ? ~b : b;
    src_c[0]   = sub | cin;
    src_sum[0] = '0;
    src_v[0]   = in_valid;
    for (int s = 1; s < STAGES; s++) begin
      src_a[s]   = a_q[s-1];
      src_b[s]   = b_q[s-1];
      src_c[s]   = c_q[s-1];
      src_sum[s] = sum_q[s-1];
      src_v[s]   = v_q[s-1];
    end
  end

  // Per-stage group evaluation; every stage either shifts forward or holds.
  always_comb begin : stage_next
    logic [WIDTH-1:0] ss;
    logic             sc;
    logic             scm;
    logic [5:0]       r;
    int               gi;
    for (int s = 0; s < STAGES; s++) begin
      ss  = src_sum[s];
      sc  = src_c[s];
      scm = 1'b0;
      r   = '0;
      for (int k = 0; k < GPS; k++) begin
        gi               = s * GPS + k;
        r                = cla4(src_a[s][gi*4 +: 4], src_b[s][gi*4 +: 4], sc);
        ss[gi*4 +: 4]    = r[3:0];
        scm              = r[4];
        sc               = r[5];
      end
      a_d[s]   = adv ? src_a[s] : a_q[s];
      b_d[s]   = adv ? src_b[s] : b_q[s];
      sum_d[s] = adv ? ss       : sum_q[s];
      c_d[s]   = adv ? sc       : c_q[s];
      cm_d[s]  = adv ? scm      : cm_q[s];
      v_d[s]   = adv ? src_v[s] : v_q[s];
    end
  end

  // Stage registers; reset clears valid bits and result fields at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= '0;
        b_q[s]   <= '0;
        sum_q[s] <= '0;
        c_q[s]   <= 1'b0;
        cm_q[s]  <= 1'b0;
        v_q[s]   <= 1'b0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        a_q[s]   <= a_d[s];
        b_q[s]   <= b_d[s];
        sum_q[s] <= sum_d[s];
        c_q[s]   <= c_d[s];
        cm_q[s]  <= cm_d[s];
        v_q[s]   <= v_d[s];
      end
    end
  end

  // Result flags come straight from the final stage register.
  always_comb begin
    out_valid = v_q[LAST];
    sum       = sum_q[LAST];
    cout      = c_q[LAST];
    ovf       = cm_q[LAST] ^ c_q[LAST];
    zero      = v_q[LAST] & ~(|sum_q[LAST]);
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;
  localparam int W = 32;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, cout, ovf, zero;

  pipelined_cla_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    logic         z;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain integer arithmetic on the effective operands.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tc, input logic ts, input int acc);
    exp_t         r;
    logic [W-1:0] be;
    logic [W:0]   t;
    be    = ts ? ~tb : tb;
    t     = {1'b0, ta} + {1'b0, be} + (W+1)'(ts ? 1'b1 : tc);
    r.s   = t[W-1:0];
    r.co  = t[W];
    r.ov  = (ta[W-1] == be[W-1]) && (t[W-1] != ta[W-1]);
    r.z   = (t[W-1:0] == '0);
    r.acc = acc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: compare the head entry while a result is presented, pop on handshake, push on accept.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got out_valid=1 sum=%h expected no result", sum);
        end else begin
          e = sb[0];
          chk("sum", sum, e.s);
          chk("cout", W'(cout), W'(e.co));
          chk("ovf", W'(ovf), W'(e.ov));
          chk("zero", W'(zero), W'(e.z));
          if (out_ready) begin
            if (lat_chk) chk("latency", W'(cyc - e.acc), W'(S));
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, cin, sub, cyc));
    end
  end

  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic ts);
    int n;
    bit acc;
    n = 0;
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got no accept expected accept within 100 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", W'(sb.size()), '0);
  endtask

  initial begin
    int c0;
    int idx;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #1;
    chk("rst_in_ready", W'(in_ready), W'(1));
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_sum", sum, '0);
    chk("rst_zero", W'(zero), '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors with exact latency.
    lat_chk = 1;
    send(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0);
    send(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0);
    send(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    send(32'd5, 32'd7, 1'b1, 1'b1);
    drain();

    // Bubble pattern 1,0,1.
    c0 = cyc;
    a = 32'h12345678; b = 32'h11111111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1 in_valid = 1'b1; a = 32'h7FFFFFFF; b = 32'h1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk); chk("bubble_c3", W'(out_valid), '0);
    @(negedge clk); chk("bubble_c4", W'(out_valid), W'(1));
    @(negedge clk); chk("bubble_c5", W'(out_valid), '0);
    @(negedge clk); chk("bubble_c6", W'(out_valid), W'(1));
    chk("bubble_cycle", W'(cyc - c0), W'(6));
    drain();
    lat_chk = 0;

    // Backpressure: 8 beats, out_ready low for 3 cycles mid-stream.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      bit acc;
      out_ready = !(c >= 6 && c < 9);
      in_valid  = (idx < 8);
      a = 32'h1000_0000 * idx + 32'h0F0F; b = 32'hF0F0 + idx; cin = idx[0]; sub = idx[1];
      @(negedge clk);
      if (c >= 6 && c < 9) chk("bp_in_ready", W'(in_ready), '0);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_all_sent", W'(idx), W'(8));
    drain();

    // Randomized traffic with random backpressure and corner operands.
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      case ($urandom % 6)
        0: a = 32'hFFFFFFFF;
        1: a = 32'h80000000;
        default: a = $urandom;
      endcase
      case ($urandom % 6)
        0: b = 32'h00000000;
        1: b = 32'h7FFFFFFF;
        default: b = $urandom;
      endcase
      cin = $urandom % 2;
      sub = $urandom % 2;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();

    // Reset with beats in flight.
    for (int i = 0; i < 5; i++) send($urandom, $urandom, 1'b0, 1'b0);
    chk("pre_rst_valid", W'(out_valid), W'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("async_out_valid", W'(out_valid), '0);
    chk("async_sum", sum, '0);
    chk("async_cout", W'(cout), '0);
    chk("async_ovf", W'(ovf), '0);
    chk("async_zero", W'(zero), '0);
    chk("async_in_ready", W'(in_ready), W'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    send(32'h00000001, 32'h00000001, 1'b1, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
